// File: rtl/control_sequencer.sv
// Multi-cycle RV32I instruction sequencer: fetch/load-IR/exec/mem/write-back
// with bus handshakes, bounded bus wait and an illegal-opcode trap state.
module control_sequencer #(
    parameter int unsigned MAX_WAIT      = 15,
    parameter bit          HAS_MEM_STAGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       stall,
    input  logic       ibus_ack,
    input  logic       dbus_ack,
    input  logic       trap_clr,
    output logic       ibus_req,
    output logic       dbus_req,
    output logic       en_iaddr,
    output logic       load_ir,
    output logic       en_pc_counter,
    output logic       mem_stage,
    output logic       write_back_stage,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [6:0] trap_opcode,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD_IR = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        TRAP    = 3'd6
    } state_t;

    localparam int unsigned    CW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam bit             TIMEOUT_ON = (MAX_WAIT > 0);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          legal;
    logic          is_mem;

    always_comb begin
        legal  = opcode inside {7'b0110011, 7'b0010011, OP_LOAD, OP_STORE, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            trap_cause  <= '0;
            trap_opcode <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
                FETCH: begin
                    if (ibus_ack) begin
                        state <= LOAD_IR;
                    end else if (TIMEOUT_ON && wait_cnt == WAIT_LAST) begin
                        state      <= TRAP;
                        trap_cause <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                LOAD_IR: state <= EXEC;
                EXEC: begin
                    if (!legal) begin
                        state       <= TRAP;
                        trap_cause  <= 2'd1;
                        trap_opcode <= opcode;
                    end else if (HAS_MEM_STAGE && is_mem) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (dbus_ack) begin
                        state <= WB;
                    end else if (TIMEOUT_ON && wait_cnt == WAIT_LAST) begin
                        state      <= TRAP;
                        trap_cause <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
                TRAP: begin
                    if (trap_clr) begin
                        state      <= FETCH;
                        wait_cnt   <= '0;
                        trap_cause <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode the state register only; en_pc_counter is additionally
    // gated by opcode, which comes from the already-latched IR during EXEC.
    always_comb begin
        ibus_req         = (state == FETCH);
        en_iaddr         = (state == FETCH) || (state == LOAD_IR);
        load_ir          = (state == LOAD_IR);
        en_pc_counter    = (state == EXEC) && legal;
        dbus_req         = (state == MEM);
        mem_stage        = (state == MEM);
        write_back_stage = (state == WB);
        trap             = (state == TRAP);
        state_o          = state;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a MAX_WAIT=4 instance with the memory
// stage and a default-wait instance without it, driven by shared inputs.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       stall, ibus_ack, dbus_ack, trap_clr;

    logic       ibus_req, dbus_req, en_iaddr, load_ir, en_pc_counter;
    logic       mem_stage, write_back_stage, trap;
    logic [1:0] trap_cause;
    logic [6:0] trap_opcode;
    logic [2:0] st;

    logic       nm_ibus_req, nm_dbus_req, nm_en_iaddr, nm_load_ir, nm_en_pc;
    logic       nm_mem_stage, nm_wb, nm_trap;
    logic [1:0] nm_trap_cause;
    logic [6:0] nm_trap_opcode;
    logic [2:0] nm_st;

    int n_checks = 0;
    int n_err    = 0;
    int pc_pulses   = 0;
    int mem_cycles  = 0;
    int nm_mem_seen = 0;
    int snap_pc, snap_mem, snap_nm;

    always #5 clk = ~clk;

    control_sequencer #(.MAX_WAIT(4), .HAS_MEM_STAGE(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
        .ibus_ack(ibus_ack), .dbus_ack(dbus_ack), .trap_clr(trap_clr),
        .ibus_req(ibus_req), .dbus_req(dbus_req), .en_iaddr(en_iaddr),
        .load_ir(load_ir), .en_pc_counter(en_pc_counter), .mem_stage(mem_stage),
        .write_back_stage(write_back_stage), .trap(trap), .trap_cause(trap_cause),
        .trap_opcode(trap_opcode), .state_o(st)
    );

    control_sequencer #(.MAX_WAIT(15), .HAS_MEM_STAGE(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
        .ibus_ack(ibus_ack), .dbus_ack(dbus_ack), .trap_clr(trap_clr),
        .ibus_req(nm_ibus_req), .dbus_req(nm_dbus_req), .en_iaddr(nm_en_iaddr),
        .load_ir(nm_load_ir), .en_pc_counter(nm_en_pc), .mem_stage(nm_mem_stage),
        .write_back_stage(nm_wb), .trap(nm_trap), .trap_cause(nm_trap_cause),
        .trap_opcode(nm_trap_opcode), .state_o(nm_st)
    );

    always @(negedge clk) begin
        if (en_pc_counter) pc_pulses++;
        if (mem_stage) mem_cycles++;
        if (nm_dbus_req || nm_mem_stage || nm_st == 3'd4) nm_mem_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; ibus_ack = 1'b0; dbus_ack = 1'b0; trap_clr = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        opcode = 7'b0110011;
        do_reset();
        // reset state
        chk("rst_state", st, 0);
        chk("rst_outs", {ibus_req, dbus_req, en_iaddr, load_ir, en_pc_counter,
                         mem_stage, write_back_stage, trap}, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_topc", trap_opcode, 0);

        // ALU instruction, ibus ack always high
        ibus_ack = 1'b1;
        step(); chk("alu_s1", st, 1); chk("alu_ireq", {ibus_req, en_iaddr}, 2'b11);
        chk("alu_pc1", en_pc_counter, 0);
        step(); chk("alu_s2", st, 2); chk("alu_ldir", {load_ir, en_iaddr}, 2'b11);
        chk("alu_pc2", en_pc_counter, 0);
        step(); chk("alu_s3", st, 3); chk("alu_pc3", en_pc_counter, 1);
        step(); chk("alu_s5", st, 5); chk("alu_wb", write_back_stage, 1);
        chk("alu_pc4", en_pc_counter, 0); chk("alu_nm_s5", nm_st, 5);
        step(); chk("alu_s1b", st, 1); chk("alu_wb_off", write_back_stage, 0);

        // LOAD, dbus ack in the third MEM cycle
        opcode = 7'b0000011;
        do_reset();
        ibus_ack = 1'b1;
        snap_mem = mem_cycles; snap_nm = nm_mem_seen;
        step(); chk("ld_s1", st, 1); chk("ld_nm_s1", nm_st, 1);
        step(); chk("ld_s2", st, 2);
        step(); chk("ld_s3", st, 3); chk("ld_pc", en_pc_counter, 1);
        step(); chk("ld_mem1", st, 4); chk("ld_dreq", {dbus_req, mem_stage}, 2'b11);
        chk("ld_nm_wb", nm_st, 5);
        step(); chk("ld_mem2", st, 4); chk("ld_nm_f", nm_st, 1);
        step(); chk("ld_mem3", st, 4);
        dbus_ack = 1'b1;
        step(); chk("ld_wb", st, 5); chk("ld_dreq_off", dbus_req, 0);
        dbus_ack = 1'b0;
        step(); chk("ld_fetch", st, 1);
        chk("ld_mem_cycles", mem_cycles - snap_mem, 3);
        chk("ld_nm_no_mem", nm_mem_seen - snap_nm, 0);

        // illegal opcode trap and clear
        opcode = 7'b1111111;
        do_reset();
        ibus_ack = 1'b1;
        snap_pc = pc_pulses;
        step(); step(); step();
        chk("ill_exec", st, 3); chk("ill_pc", en_pc_counter, 0);
        step(); chk("ill_trap", st, 6); chk("ill_trapo", trap, 1);
        chk("ill_cause", trap_cause, 1); chk("ill_topc", trap_opcode, 7'h7F);
        chk("ill_strobes", {ibus_req, dbus_req, en_iaddr, load_ir, en_pc_counter,
                            mem_stage, write_back_stage}, 0);
        step(); chk("ill_hold", st, 6);
        chk("ill_no_pc", pc_pulses - snap_pc, 0);
        trap_clr = 1'b1;
        step(); chk("ill_clr_s", st, 1); chk("ill_clr_cause", trap_cause, 0);
        chk("ill_keep_topc", trap_opcode, 7'h7F);
        trap_clr = 1'b0;

        // ibus timeout with MAX_WAIT=4
        opcode = 7'b0110011;
        do_reset();
        chk("to_topc_rst", trap_opcode, 0);
        step(); chk("to_f1", st, 1);
        step(); chk("to_f2", st, 1);
        step(); chk("to_f3", st, 1);
        step(); chk("to_f4", st, 1);
        step(); chk("to_trap", st, 6); chk("to_cause", trap_cause, 2);
        chk("to_nm_wait", nm_st, 1);
        trap_clr = 1'b1;
        step(); chk("to_clr", st, 1); chk("to_clr_cause", trap_cause, 0);
        trap_clr = 1'b0;
        step(); chk("to2_f2", st, 1);
        step(); chk("to2_f3", st, 1);
        step(); chk("to2_f4", st, 1);
        ibus_ack = 1'b1;
        step(); chk("to2_ldir", st, 2); chk("to2_notrap", trap, 0);

        // stall in MEM: counter frozen, acks ignored, ack wins on expiry cycle
        opcode = 7'b0100011;
        do_reset();
        ibus_ack = 1'b1;
        step(); step(); step(); step();
        chk("st_mem", st, 4);
        step(); chk("st_mem_c1", st, 4);
        stall = 1'b1;
        step(); step(); step();
        chk("st_frz0", st, 4); chk("st_frz0_req", dbus_req, 1);
        stall = 1'b0;
        step(); chk("st_c2", st, 4);
        step(); chk("st_c3", st, 4);
        stall = 1'b1; dbus_ack = 1'b1;
        step(); chk("st_ack_ign1", st, 4);
        step(); chk("st_ack_ign2", st, 4);
        step(); chk("st_ack_ign3", st, 4); chk("st_ms", mem_stage, 1);
        stall = 1'b0;
        step(); chk("st_wb", st, 5); chk("st_notrap", trap, 0);
        dbus_ack = 1'b0;
        step(); step(); step(); step();
        chk("rm_mem", st, 4); chk("rm_dreq", dbus_req, 1);
        #3 rst = 1'b0;
        #1;
        chk("rm_dreq_off", dbus_req, 0); chk("rm_state", st, 0);
        chk("rm_ms_off", mem_stage, 0);
        step();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
